term_batch_buffer: RTL

//  State/storage stage around ctrl_terminate. Holds the two 64-bit accumulation buffers, the

---
 rtl/term_batch_buffer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/term_batch_buffer.sv
// term_batch_buffer: state and storage around ctrl_terminate.
// Holds the two bitmap accumulation buffers, the active-buffer select, the
// batch tag and the CVT waiting-thread count. Batches closed by
// ctrl_terminate are queued in a small FIFO and offered to the CVT over a
// valid/ready handshake.
module term_batch_buffer #(
  parameter int DEPTH = 4,
  parameter int WT_W  = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            token_valid,
  input  logic [9:0]      token_buffer,
  input  logic            token_ctrl,
  output logic            token_ready,
  input  logic [63:0]     updated_data_1,
  input  logic [63:0]     updated_data_2,
  input  logic            send_batch,
  input  logic            new_batch,
  output logic [63:0]     old_data,
  output logic [3:0]      batch_base,
  output logic            condition,
  output logic            cur_batch,
  output logic [WT_W-1:0] waiting_threads,
  output logic            batch_valid,
  input  logic            batch_ready,
  output logic [63:0]     batch_bitmap,
  output logic [3:0]      batch_base_out,
  output logic            batch_ctrl,
  output logic [6:0]      batch_count,
  input  logic            cvt_release,
  input  logic [6:0]      cvt_release_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = WT_W + 2;

  // Number of set bits in a 64-bit bitmap (0..64).
  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) begin
      c = c + {6'd0, v[i]};
    end
    return c;
  endfunction

  // Clamp a signed net count into the unsigned waiting_threads range.
  // The sum never exceeds twice the range, so bit WT_W flags overflow.
  function automatic logic [WT_W-1:0] sat_wt(input logic signed [SW-1:0] v);
    if (v[SW-1]) begin
      return '0;
    end else if (v[WT_W]) begin
      return '1;
    end else begin
      return v[WT_W-1:0];
    end
  endfunction

  // Accumulation buffers
  logic [63:0] buf1;
  logic [63:0] buf2;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [63:0] fifo_bitmap [DEPTH];
  logic [3:0]  fifo_base   [DEPTH];
  logic        fifo_ctrl   [DEPTH];
  logic [6:0]  fifo_cnt    [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic        fifo_empty;
  logic        fifo_full;

  // Handshake terms
  logic        pop;
  logic        push;
  logic        stall;
  logic        do_push;
  logic [6:0]  push_cnt;

  // Waiting-thread arithmetic
  logic [6:0]           pop_cnt;
  logic [6:0]           rel_cnt;
  logic signed [SW-1:0] wt_sum;

  // Bit index of the token is consumed by ctrl_terminate only.
  logic unused_tid_bits;
  assign unused_tid_bits = ^token_buffer[5:0];

  assign old_data   = cur_batch ? buf2 : buf1;

  assign wr_idx     = wr_ptr[AW-1:0];
  assign rd_idx     = rd_ptr[AW-1:0];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

  assign batch_valid = ~fifo_empty;
  assign pop         = batch_valid & batch_ready;
  assign push        = send_batch & (old_data != 64'd0);
  // A pop in the same cycle frees the slot, so full-with-pop still accepts.
  assign stall       = push & fifo_full & ~pop;
  assign do_push     = push & ~stall;
  assign token_ready = ~stall;
  assign push_cnt    = popcount64(old_data);

  // Head outputs read as zero while the FIFO is empty.
  assign batch_bitmap   = batch_valid ? fifo_bitmap[rd_idx] : 64'd0;
  assign batch_base_out = batch_valid ? fifo_base[rd_idx]   : 4'd0;
  assign batch_ctrl     = batch_valid ? fifo_ctrl[rd_idx]   : 1'b0;
  assign batch_count    = batch_valid ? fifo_cnt[rd_idx]    : 7'd0;

  assign pop_cnt = pop         ? batch_count     : 7'd0;
  assign rel_cnt = cvt_release ? cvt_release_cnt : 7'd0;
  assign wt_sum  = $signed({2'b00, waiting_threads})
                 + $signed({{(SW-7){1'b0}}, pop_cnt})
                 - $signed({{(SW-7){1'b0}}, rel_cnt});

  // Buffers and active select follow ctrl_terminate unless the FIFO stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf1      <= 64'd0;
      buf2      <= 64'd0;
      cur_batch <= 1'b0;
    end else if (!stall) begin
      buf1      <= updated_data_1;
      buf2      <= updated_data_2;
      cur_batch <= new_batch;
    end
  end

  // The batch tag moves to the token that opened the new batch; a
  // threshold flush (no token) leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      batch_base <= 4'd0;
      condition  <= 1'b0;
    end else if (token_valid && send_batch && !stall) begin
      batch_base <= token_buffer[9:6];
      condition  <= token_ctrl;
    end
  end

  // FIFO entry storage; validity is carried by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_bitmap[wr_idx] <= old_data;
      fifo_base[wr_idx]   <= batch_base;
      fifo_ctrl[wr_idx]   <= condition;
      fifo_cnt[wr_idx]    <= push_cnt;
    end
  end

  // FIFO pointers; reset discards every queued entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Net waiting-thread update: popped batches enter, released threads leave.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waiting_threads <= '0;
    end else begin
      waiting_threads <= sat_wt(wt_sum);
    end
  end

endmodule
